// File: rtl/arb_seq_gen_param.sv
// arb_seq_gen_param: keypad-driven SEQ_W-bit pattern editor and timed rotation sequencer
//   clk    in            system clock
//   rst    in            synchronous active-high reset
//   row    in  [3:0]     keypad rows, active-low
//   col    out [3:0]     keypad column drive, one-hot active-low
//   led    out [SEQ_W]   current display pattern
//   buzzer out           completion alarm, active-high
//   busy   out           high while running or paused
module arb_seq_gen_param #(
    parameter int SEQ_W       = 8,
    parameter int SCAN_CYCLES = 100000,
    parameter int DEB_FRAMES  = 3,
    parameter int STEP_CYCLES = 100000000,
    parameter int RUN_STEPS   = 8,
    parameter int BEEP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [SEQ_W-1:0] led,
    output logic             buzzer,
    output logic             busy
);
    localparam int SCW = $clog2(SCAN_CYCLES + 1);
    localparam int DW  = $clog2(DEB_FRAMES + 1);
    localparam int TW  = $clog2(STEP_CYCLES + 1);
    localparam int SW  = $clog2(RUN_STEPS + 1);
    localparam int BW  = $clog2(BEEP_CYCLES + 2);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;

    logic [SCW-1:0]   scan_q;
    logic [1:0]       cidx_q;
    logic [4:0]       fcode_q, fcode_d, last_q, stable_q, stable_d, scode;
    logic             fbad_q, fbad_d, ev_q;
    logic [DW-1:0]    deb_q, deb_d;
    logic [3:0]       low;
    logic [1:0]       rbit;
    logic             slot_end, frame_end, multi;

    logic [1:0]       st_q, st_d;
    logic [SEQ_W-1:0] led_q, led_d, edit_q, edit_d, rotl, rotr;
    logic             dir_q, dir_d, buz_q, buz_d, wrap, idle;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [SW-1:0]    step_q, step_d;
    logic [BW-1:0]    beep_q, beep_d;
    logic [4:0]       k;

    // Each frame merges four column samples; a second key or a multi-row sample poisons it.
    always_comb begin
        low       = ~row;
        slot_end  = scan_q == SCW'(SCAN_CYCLES - 1);
        frame_end = slot_end && cidx_q == 2'd3;
        multi     = (low & (low - 4'd1)) != 4'd0;
        rbit      = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
        scode     = low == 4'd0 ? 5'd0 : {1'b0, rbit, cidx_q} + 5'd1;
        fcode_d   = fcode_q != 5'd0 ? fcode_q : scode;
        fbad_d    = fbad_q || multi || (fcode_q != 5'd0 && scode != 5'd0);
        deb_d     = fbad_d ? '0 : fcode_d != last_q ? DW'(1) :
                    deb_q == DW'(DEB_FRAMES) ? deb_q : deb_q + DW'(1);
        stable_d  = frame_end && !fbad_d && deb_d == DW'(DEB_FRAMES) ? fcode_d : stable_q;
    end

    always_comb begin
        st_d   = st_q;
        led_d  = led_q;
        edit_d = edit_q;
        dir_d  = dir_q;
        tmr_d  = tmr_q;
        step_d = step_q;
        buz_d  = buz_q;
        beep_d = '0;
        k      = stable_q;
        idle   = st_q == IDLE || st_q == DONE;
        rotl   = (led_q << 1) | (led_q >> (SEQ_W - 1));
        rotr   = (led_q >> 1) | (led_q << (SEQ_W - 1));
        wrap   = st_q == RUN && tmr_q == TW'(STEP_CYCLES - 1);
        if (st_q == RUN) begin
            tmr_d = wrap ? '0 : tmr_q + TW'(1);
            if (wrap) begin
                led_d  = dir_q ? rotr : rotl;
                step_d = step_q + SW'(1);
                if (step_q + SW'(1) == SW'(RUN_STEPS)) begin
                    st_d  = DONE;
                    buz_d = 1'b1;
                end
            end
        end
        if (BEEP_CYCLES > 0 && buz_q) begin
            beep_d = beep_q + BW'(1);
            if (beep_q == BW'(BEEP_CYCLES - 1)) begin
                buz_d  = 1'b0;
                beep_d = '0;
            end
        end
        // Key actions are applied after the step so a same-cycle pause sees the advanced state.
        if (ev_q) begin
            if (k <= 5'(SEQ_W)) begin
                if (idle) edit_d = edit_q ^ (SEQ_W'(1) << (k - 5'd1));
            end else if (k == 5'd9) begin
                dir_d = !dir_q;
            end else if (k == 5'd10) begin
                st_d = st_d == RUN ? PAUSE : st_q == PAUSE ? RUN : st_d;
            end else if (k == 5'd13) begin
                buz_d  = 1'b0;
                beep_d = '0;
            end else if (k == 5'd14) begin
                if (idle) led_d = edit_q;
            end else if (k == 5'd15) begin
                edit_d = '0;
                led_d  = '0;
                buz_d  = 1'b0;
                beep_d = '0;
                dir_d  = 1'b0;
                step_d = '0;
                tmr_d  = '0;
                st_d   = IDLE;
            end else if (k == 5'd16 && idle) begin
                led_d  = edit_q;
                step_d = '0;
                tmr_d  = '0;
                buz_d  = 1'b0;
                beep_d = '0;
                st_d   = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q   <= '0;
            cidx_q   <= 2'd0;
            fcode_q  <= 5'd0;
            fbad_q   <= 1'b0;
            last_q   <= 5'd0;
            deb_q    <= '0;
            stable_q <= 5'd0;
            ev_q     <= 1'b0;
            st_q     <= IDLE;
            led_q    <= '0;
            edit_q   <= '0;
            dir_q    <= 1'b0;
            tmr_q    <= '0;
            step_q   <= '0;
            buz_q    <= 1'b0;
            beep_q   <= '0;
        end else begin
            scan_q <= slot_end ? '0 : scan_q + SCW'(1);
            if (slot_end) begin
                cidx_q  <= cidx_q + 2'd1;
                fcode_q <= frame_end ? 5'd0 : fcode_d;
                fbad_q  <= !frame_end && fbad_d;
            end
            if (frame_end) begin
                deb_q  <= deb_d;
                last_q <= fbad_d ? last_q : fcode_d;
            end
            stable_q <= stable_d;
            ev_q     <= stable_q == 5'd0 && stable_d != 5'd0;
            st_q     <= st_d;
            led_q    <= led_d;
            edit_q   <= edit_d;
            dir_q    <= dir_d;
            tmr_q    <= tmr_d;
            step_q   <= step_d;
            buz_q    <= buz_d;
            beep_q   <= beep_d;
        end
    end

    assign col    = ~(4'b0001 << cidx_q);
    assign led    = led_q;
    assign buzzer = buz_q;
    assign busy   = st_q == RUN || st_q == PAUSE;
endmodule

// File: tb/tb_arb_seq_gen_param.sv
// tb_arb_seq_gen_param: scoreboard bench for the keypad sequence generator
module tb_arb_seq_gen_param;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row, col;
    logic [7:0] led;
    logic       buzzer, busy;
    int         key = 0;
    int         cyc = 0, base = 0, last = 0, checks = 0, failures = 0;
    bit         mon_en = 1'b0;
    logic [9:0] prev;

    typedef struct {
        logic [7:0] led;
        logic       buz;
        logic       busy;
        int         gap;
    } exp_t;
    exp_t q[$];
    exp_t e;

    arb_seq_gen_param #(
        .SEQ_W(8), .SCAN_CYCLES(4), .DEB_FRAMES(2),
        .STEP_CYCLES(10), .RUN_STEPS(8), .BEEP_CYCLES(0)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .led(led), .buzzer(buzzer), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: key k closes row (k-1)/4 onto column (k-1)%4.
    always_comb begin
        row = 4'hF;
        if (key != 0 && col == 4'(~(4'b0001 << ((key - 1) % 4))))
            row = 4'(~(4'b0001 << ((key - 1) / 4)));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] l, input logic b, input logic y, input int g);
        q.push_back('{l, b, y, g});
    endtask

    task automatic align();
        while ((cyc - base) % 16 != 0) @(negedge clk);
    endtask

    task automatic press(input int k, input int hold = 2, input int rel = 2);
        align();
        key = k;
        repeat (16 * hold) @(negedge clk);
        key = 0;
        repeat (16 * rel) @(negedge clk);
    endtask

    // Monitor: every change of the visible outputs consumes one scoreboard entry.
    always @(negedge clk) begin
        if (mon_en && {led, buzzer, busy} != prev) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_change actual=%0h expected=%0h at cycle %0d",
                         {led, buzzer, busy}, prev, cyc);
            end else begin
                e = q.pop_front();
                chk("led", int'(led), int'(e.led));
                chk("buzzer", int'(buzzer), int'(e.buz));
                chk("busy", int'(busy), int'(e.busy));
                if (e.gap != 0) chk("step_gap", cyc - last, e.gap);
            end
            prev = {led, buzzer, busy};
            last = cyc;
        end
    end

    initial begin
        logic [7:0] run1[7];
        logic [7:0] run2[6];
        logic [7:0] run3[6];
        run1 = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC1};
        run2 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
        run3 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_col", int'(col), 4'hE);
        chk("reset_led", int'(led), 0);
        chk("reset_buzzer", int'(buzzer), 0);
        chk("reset_busy", int'(busy), 0);
        rst    = 1'b0;
        base   = cyc;
        prev   = {led, buzzer, busy};
        last   = cyc;
        mon_en = 1'b1;

        // Long hold yields one event; release and re-press a second; third press sets bit 2.
        press(3, 5, 2);
        press(3);
        press(3);
        push(8'h04, 1'b0, 1'b0, 0);
        press(14);

        // One-frame glitch must not toggle; a real press then clears bit 2.
        align();
        key = 3;
        repeat (16) @(negedge clk);
        key = 0;
        repeat (32) @(negedge clk);
        press(3);
        push(8'h00, 1'b0, 1'b0, 0);
        press(14);

        // Load 8'h83.
        press(1);
        press(2);
        press(8);
        push(8'h83, 1'b0, 1'b0, 0);
        press(14);

        // Left run of 8'h83; J5 mid-run and J14 in DONE change nothing; J13 silences.
        push(8'h83, 1'b0, 1'b1, 0);
        foreach (run1[i]) push(run1[i], 1'b0, 1'b1, 10);
        push(8'h83, 1'b1, 1'b0, 10);
        press(16);
        press(5);
        press(14);
        push(8'h83, 1'b0, 1'b0, 0);
        press(13);

        push(8'h00, 1'b0, 1'b0, 0);
        press(15);

        // Run 8'h01: pause after step 6, flip direction while paused, resume with 6 cycles left.
        press(1);
        push(8'h01, 1'b0, 1'b1, 0);
        foreach (run2[i]) push(run2[i], 1'b0, 1'b1, 10);
        push(8'h20, 1'b0, 1'b1, 138);
        push(8'h10, 1'b1, 1'b0, 10);
        press(16);
        press(10);
        press(9);
        press(10);
        push(8'h10, 1'b0, 1'b0, 0);
        press(13);

        // Right run paused; J14 and J16 ignored; J15 clears to idle.
        push(8'h01, 1'b0, 1'b1, 0);
        foreach (run3[i]) push(run3[i], 1'b0, 1'b1, 10);
        press(16);
        press(10);
        press(14);
        press(16);
        push(8'h00, 1'b0, 1'b0, 0);
        press(15);

        // Reset during a run.
        press(1);
        push(8'h01, 1'b0, 1'b1, 0);
        push(8'h02, 1'b0, 1'b1, 10);
        push(8'h04, 1'b0, 1'b1, 10);
        push(8'h08, 1'b0, 1'b1, 10);
        press(16);
        push(8'h00, 1'b0, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_reset_col", int'(col), 4'hE);
        chk("midrun_reset_led", int'(led), 0);
        chk("midrun_reset_buzzer", int'(buzzer), 0);
        chk("midrun_reset_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (64) @(negedge clk);

        chk("scoreboard_leftover", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arb_seq_gen_param.md
Name: arb_seq_gen_param

Overview:
Parametrised arbitrary-sequence generator driven by the 4x4 matrix keypad.
- The user toggles bits of a SEQ_W-bit pattern, then loads it onto the LEDs and runs it as a timed rotation, left or right, with pause/resume.
- The buzzer sounds on completion.
- Sits between the keypad/LED/buzzer pins and replaces the fixed 8-bit, level-triggered generator with edge-triggered key events and a proper run FSM.

Parameters:
SEQ_W, 8, pattern/LED width (1..8; keys J1..J(SEQ_W) toggle bits 0..SEQ_W-1)
SCAN_CYCLES, 100000, clk cycles each keypad column is driven
DEB_FRAMES, 3, consecutive identical scan frames required to accept a key state
STEP_CYCLES, 100000000, clk cycles per rotation step
RUN_STEPS, 8, rotation steps per run (>=1)
BEEP_CYCLES, 0, buzzer auto-off time after completion; 0 = hold until cleared by key

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
row  in  4  keypad rows, active-low
col  out  4  keypad column drive, one-hot active-low
led  out  SEQ_W  current display pattern
buzzer  out  1  completion alarm, active-high
busy  out  1  high in RUN or PAUSE

Behaviour:
- Reset state: col=4'b1110, led=0, buzzer=0, busy=0, edit pattern=0, dir=left, FSM=IDLE. All counters are 0.
- Clock/reset: single clk domain; rst is synchronous, active-high, and takes priority over all key events.
- Scanner: col rotates 1110->1101->1011->0111->1110, advancing every SCAN_CYCLES.
- Row sampling: row is sampled in the last cycle of each column slot.
- Key codes: column c (0..3) with row bit r low gives code = 4*r + c + 1 (J1..J16).
- Frames: 4 slots form one frame. The frame code is the key found in the frame, or 0 if every sample was 4'b1111.
- Invalid frames: a frame with any sample having more than one low row bit, or with keys found in two columns, is invalid. An invalid frame resets the debounce count.
- Debounce: the stable code updates when the frame code is identical for DEB_FRAMES consecutive frames.
- Key event: a 1-cycle event fires when the stable code goes from 0 to nonzero. Holding a key gives exactly one event; a new event requires release (stable 0) first.
- Event latency: at most (DEB_FRAMES+1)*4*SCAN_CYCLES+2 clk after row settles.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Key J1..J(SEQ_W): in IDLE/DONE, toggle edit[k-1]. Ignored in RUN/PAUSE. Keys J(SEQ_W+1)..J8 are ignored.
- Key J9: toggle dir in any state. Takes effect at the next step.
- Key J10: RUN->PAUSE or PAUSE->RUN. The step timer freezes in PAUSE and resumes from its held value. Ignored elsewhere.
- Key J13: buzzer=0 in any state; the FSM is unchanged.
- Key J14: in IDLE/DONE, led<=edit. Ignored in RUN/PAUSE.
- Key J15: from any state, edit=0, led=0, buzzer=0, dir=left, step/timer=0, ->IDLE.
- Key J16: in IDLE/DONE, led<=edit, step=0, timer=0, buzzer=0, ->RUN. Ignored in RUN/PAUSE (no restart).
- Keys J11, J12: reserved; no effect.
- RUN timing: the timer counts 0..STEP_CYCLES-1. On wrap, led rotates one position:
  - left: {led[SEQ_W-2:0], led[SEQ_W-1]}
  - right: {led[0], led[SEQ_W-1:1]}
  - step increments on each wrap.
  - The first step occurs STEP_CYCLES clk after the J16 event.
- Completion: when step reaches RUN_STEPS, same cycle ->DONE, buzzer=1, busy=0; led holds its final pattern.
- DONE: if BEEP_CYCLES>0, buzzer clears after BEEP_CYCLES clk. J13, J15 or J16 clear it earlier.
- SEQ_W=1: rotation leaves led unchanged, but steps and completion still occur.
- Simultaneous events: a step wrap and a J10 in the same cycle apply the step first, then pause. Only one key event can exist per cycle.
- Reset mid-run: returns immediately to the reset state; no buzzer.

Test Plan:
Parameters for all scenarios: SEQ_W=8, SCAN_CYCLES=4, DEB_FRAMES=2, STEP_CYCLES=10, RUN_STEPS=8, BEEP_CYCLES=0.
- Debounce: hold J3 (row0 low during col 1011) for 5 frames, release, hold again -> exactly 2 toggle events; edit=8'b00000000 after both. Glitch J3 for 1 frame -> no event.
- Load: press J1, J2, J8, then J14 -> led=8'h83, busy=0.
- Run left: edit=8'h83, press J16 -> led=8'h07 at +10 clk, 8'h0E at +20. After 8 steps led=8'h83, buzzer=1, busy=0.
- Direction/pause: run 8'h01, J9 after step 2 -> led 04,02,01,80...; J10 freezes led for 100 clk, second J10 resumes with remaining timer count.
- Clear/ignore: during RUN press J5 and J14 -> no change. J15 -> led=0, buzzer=0, IDLE. In DONE, J13 -> buzzer=0 with led held.
- Reset: assert rst mid-run -> next clk led=0, col=4'b1110, buzzer=0, busy=0.
